fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that feeds the IF/ID pipeline register. Holds the PC and runs the
//  instruction-memory request/ready handshake. Presents {instr_o, next_pc_o} for capture at the
//  next clk edge, or a NOP bubble when no instruction is available. Handles stall hold,
//  branch/jump redirect, and discard of in-flight fetches.
// PARAMETERS
//  RESET_PC  16'h0000  PC loaded on reset
//  PC_STEP   16'd1     PC increment per instruction (word-addressed imem)
//  NOP       16'hE800  bubble instruction; must match the NOP used by the IF/ID register
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  stall_i        in   1   downstream hold (same signal that holds the IF/ID register)
//  redirect_i     in   1   taken branch/jump; flush and refetch at redirect_pc_i
//  redirect_pc_i  in   16  redirect target
//  imem_req_o     out  1   fetch request; held with imem_addr_o until imem_ready_i
//  imem_addr_o    out  16  fetch address
//  imem_rdata_i   in   16  instruction word; valid only when imem_ready_i=1
//  imem_ready_i   in   1   memory completes the request this cycle
//  instr_o        out  16  instruction to IF/ID register (NOP when instr_valid_o=0)
//  next_pc_o      out  16  PC of the following instruction (pc+PC_STEP) to IF/ID register
//  instr_valid_o  out  1   instr_o is a real fetched instruction
//  pc_o           out  16  current PC register (debug/trace)
// BEHAVIOUR
//  Registers: pc, state{FETCH,HOLD,DISCARD}, hold_instr, discard_addr. Outputs combinational from these.
//  Reset (async): state=FETCH, pc=RESET_PC, hold_instr=NOP. While rst=1: imem_req_o=0,
//   instr_o=NOP, instr_valid_o=0, next_pc_o=pc_o=RESET_PC. A reset mid-transaction abandons the
//   outstanding request. The imem shares rst.
//  Handshake: the request completes at the posedge where imem_req_o & imem_ready_i. Address is held
//   stable while waiting. Zero-wait memory gives 1 instr/cycle; first instr appears in the first
//   cycle after rst falls.
//  FETCH: req=1, addr=pc.
//   redirect_i: pc<=redirect_pc_i; output NOP/valid=0; if ready stay FETCH, else discard_addr<=pc and go DISCARD.
//   else !ready: output NOP, valid=0, next_pc_o=pc; hold.
//   else ready & !stall_i: instr_o=rdata, valid=1, next_pc_o=pc+PC_STEP; pc<=pc+PC_STEP.
//   else ready & stall_i: present rdata (ignored by the stalled register); hold_instr<=rdata; go HOLD.
//  HOLD: req=0; instr_o=hold_instr, valid=1, next_pc_o=pc+PC_STEP.
//   redirect_i: output NOP; pc<=redirect_pc_i; go FETCH.
//   else !stall_i: pc<=pc+PC_STEP; go FETCH.
//   else remain in HOLD; no refetch.
//  DISCARD: req=1, addr=discard_addr; output NOP, valid=0.
//   ready: drop rdata; go FETCH.
//   redirect_i: pc<=redirect_pc_i in any case.
//  Priority: rst > redirect_i > stall_i > ready. Redirect during stall still flushes (NOP presented).
//  Arithmetic: 16-bit modulo; pc 16'hFFFF + 1 wraps to 16'h0000, and next_pc_o wraps the same way.
//  A stall with no instruction (FETCH, !ready) has no effect beyond outputting NOP; the fetch continues.
// TESTING
//  1 Reset, zero-wait imem holding mem[i]=i+16'h1000 -> cycles give instr 1000,1001,1002;
//    next_pc 1,2,3; valid=1 each cycle.
//  2 stall_i high 3 cycles while ready at pc=5 -> instr 1005 held in HOLD with req=0 and pc=5;
//    on release pc->6 and the next fetch is addr 6.
//  3 ready delayed 2 cycles at addr 8 -> NOP, valid=0 for 2 cycles; req/addr=8 stable;
//    then instr 1008 is presented.
//  4 Redirect to 16'h0040 while addr 9 is waiting -> DISCARD holds addr 9 until ready; that data
//    is dropped (NOP out); then addr 40 is fetched and instr 1040 is presented.
//  5 Redirect coincident with stall_i in HOLD -> NOP output, pc=redirect_pc_i, next request uses
//    the redirect target.
//  6 RESET_PC=16'hFFFF -> next_pc_o=0000 and second fetch addr=0000. Assert rst during a waiting
//    request -> req=0 immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ready handshake, stall hold, redirect and in-flight discard.
// Outputs are combinational from pc/state/hold_instr/discard_addr; zero-wait imem sustains 1 instr/cycle.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1,
  parameter logic [15:0] NOP      = 16'hE800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [15:0] instr_o,
  output logic [15:0] next_pc_o,
  output logic        instr_valid_o,
  output logic [15:0] pc_o
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] hold_instr, hold_nxt;
  logic [15:0] discard_addr, discard_nxt;
  logic [15:0] pc_inc;

  assign pc_inc = pc + PC_STEP;
  assign pc_o   = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      hold_instr   <= NOP;
      discard_addr <= RESET_PC;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      hold_instr   <= hold_nxt;
      discard_addr <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    hold_nxt      = hold_instr;
    discard_nxt   = discard_addr;
    imem_req_o    = 1'b0;
    imem_addr_o   = pc;
    instr_o       = NOP;
    instr_valid_o = 1'b0;
    next_pc_o     = pc;

    case (state)
      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          pc_nxt = redirect_pc_i;
          // The unanswered request must still be drained before refetching.
          if (!imem_ready_i) begin
            discard_nxt = pc;
            state_nxt   = DISCARD;
          end
        end else if (imem_ready_i) begin
          instr_o       = imem_rdata_i;
          instr_valid_o = 1'b1;
          next_pc_o     = pc_inc;
          if (stall_i) begin
            hold_nxt  = imem_rdata_i;
            state_nxt = HOLD;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end

      HOLD: begin
        if (redirect_i) begin
          pc_nxt    = redirect_pc_i;
          state_nxt = FETCH;
        end else begin
          instr_o       = hold_instr;
          instr_valid_o = 1'b1;
          next_pc_o     = pc_inc;
          if (!stall_i) begin
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        end
      end

      DISCARD: begin
        imem_req_o  = 1'b1;
        imem_addr_o = discard_addr;
        if (redirect_i) pc_nxt = redirect_pc_i;
        if (imem_ready_i) state_nxt = FETCH;
      end

      default: state_nxt = FETCH;
    endcase

    // Reset abandons any outstanding request immediately.
    if (rst) begin
      imem_req_o    = 1'b0;
      instr_o       = NOP;
      instr_valid_o = 1'b0;
      next_pc_o     = RESET_PC;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait, stall, wait states, redirect/discard, PC wrap, reset mid-request.
module tb_fetch_unit;

  logic        clk, rst, rst2;
  logic        stall, redirect, ready;
  logic [15:0] redirect_pc;
  logic        req, valid, req2, valid2;
  logic [15:0] addr, rdata, instr, next_pc, pc;
  logic [15:0] addr2, rdata2, instr2, next_pc2, pc2;

  int checks = 0;
  int errors = 0;

  // Memory model: mem[i] = i + 16'h1000
  assign rdata  = addr + 16'h1000;
  assign rdata2 = addr2 + 16'h1000;

  // obs layout: req[65] addr[64:49] instr[48:33] valid[32] next_pc[31:16] pc[15:0]
  logic [65:0] obs, obs2;
  assign obs  = {req, addr, instr, valid, next_pc, pc};
  assign obs2 = {req2, addr2, instr2, valid2, next_pc2, pc2};

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .instr_o(instr), .next_pc_o(next_pc), .instr_valid_o(valid), .pc_o(pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst2), .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2), .imem_ready_i(ready),
    .instr_o(instr2), .next_pc_o(next_pc2), .instr_valid_o(valid2), .pc_o(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #2;
    checks++;
    if ({obs[65], obs[48:0]} !== {1'b0, 16'hE800, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", {obs[65], obs[48:0]},
               {1'b0, 16'hE800, 1'b0, 16'h0000, 16'h0000});
    end
  endtask

  task automatic test_zero_wait;
    logic [15:0] k;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      k = 16'(i);
      checks++;
      if (obs !== {1'b1, k, 16'h1000 + k, 1'b1, k + 16'd1, k}) begin
        errors++;
        $display("FAIL zero_wait[%0d]: got %h want %h", i, obs, {1'b1, k, 16'h1000 + k, 1'b1, k + 16'd1, k});
      end
    end
  endtask

  task automatic test_stall;
    @(negedge clk); @(negedge clk);
    @(negedge clk); stall = 1'b1; #1;
    checks++;
    if (obs !== {1'b1, 16'h0005, 16'h1005, 1'b1, 16'h0006, 16'h0005}) begin
      errors++;
      $display("FAIL stall_capture: got %h want %h", obs, {1'b1, 16'h0005, 16'h1005, 1'b1, 16'h0006, 16'h0005});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) stall = 1'b0;
      #1;
      checks++;
      if ({obs[65], obs[48:0]} !== {1'b0, 16'h1005, 1'b1, 16'h0006, 16'h0005}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, {obs[65], obs[48:0]},
                 {1'b0, 16'h1005, 1'b1, 16'h0006, 16'h0005});
      end
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 16'h0006, 16'h1006, 1'b1, 16'h0007, 16'h0006}) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", obs, {1'b1, 16'h0006, 16'h1006, 1'b1, 16'h0007, 16'h0006});
    end
  endtask

  task automatic test_wait_states;
    @(negedge clk);
    @(negedge clk); ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs !== {1'b1, 16'h0008, 16'hE800, 1'b0, 16'h0008, 16'h0008}) begin
        errors++;
        $display("FAIL wait_nop[%0d]: got %h want %h", i, obs, {1'b1, 16'h0008, 16'hE800, 1'b0, 16'h0008, 16'h0008});
      end
    end
    @(negedge clk); ready = 1'b1; #1;
    checks++;
    if (obs !== {1'b1, 16'h0008, 16'h1008, 1'b1, 16'h0009, 16'h0008}) begin
      errors++;
      $display("FAIL wait_done: got %h want %h", obs, {1'b1, 16'h0008, 16'h1008, 1'b1, 16'h0009, 16'h0008});
    end
  endtask

  task automatic test_redirect_discard;
    @(negedge clk); ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040; #1;
    checks++;
    if (obs[65:32] !== {1'b1, 16'h0009, 16'hE800, 1'b0}) begin
      errors++;
      $display("FAIL redirect_fetch: got %h want %h", obs[65:32], {1'b1, 16'h0009, 16'hE800, 1'b0});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); redirect = 1'b0;
      if (i == 1) ready = 1'b1;
      #1;
      checks++;
      if ({obs[65:32], obs[15:0]} !== {1'b1, 16'h0009, 16'hE800, 1'b0, 16'h0040}) begin
        errors++;
        $display("FAIL discard[%0d]: got %h want %h", i, {obs[65:32], obs[15:0]},
                 {1'b1, 16'h0009, 16'hE800, 1'b0, 16'h0040});
      end
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== {1'b1, 16'h0040, 16'h1040, 1'b1, 16'h0041, 16'h0040}) begin
      errors++;
      $display("FAIL redirect_target: got %h want %h", obs, {1'b1, 16'h0040, 16'h1040, 1'b1, 16'h0041, 16'h0040});
    end
  endtask

  task automatic test_redirect_in_hold;
    @(negedge clk); stall = 1'b1; #1;
    checks++;
    if (obs !== {1'b1, 16'h0041, 16'h1041, 1'b1, 16'h0042, 16'h0041}) begin
      errors++;
      $display("FAIL hold_entry: got %h want %h", obs, {1'b1, 16'h0041, 16'h1041, 1'b1, 16'h0042, 16'h0041});
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0080; #1;
    checks++;
    if ({obs[65], obs[48:32]} !== {1'b0, 16'hE800, 1'b0}) begin
      errors++;
      $display("FAIL hold_redirect: got %h want %h", {obs[65], obs[48:32]}, {1'b0, 16'hE800, 1'b0});
    end
    @(negedge clk); stall = 1'b0; redirect = 1'b0; #1;
    checks++;
    if (obs !== {1'b1, 16'h0080, 16'h1080, 1'b1, 16'h0081, 16'h0080}) begin
      errors++;
      $display("FAIL hold_refetch: got %h want %h", obs, {1'b1, 16'h0080, 16'h1080, 1'b1, 16'h0081, 16'h0080});
    end
  endtask

  task automatic test_reset_mid_request;
    @(negedge clk); ready = 1'b0; #1;
    checks++;
    if (obs !== {1'b1, 16'h0081, 16'hE800, 1'b0, 16'h0081, 16'h0081}) begin
      errors++;
      $display("FAIL pre_reset_wait: got %h want %h", obs, {1'b1, 16'h0081, 16'hE800, 1'b0, 16'h0081, 16'h0081});
    end
    #1; rst = 1'b1; #1;
    checks++;
    if ({obs[65], obs[48:0]} !== {1'b0, 16'hE800, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", {obs[65], obs[48:0]},
               {1'b0, 16'hE800, 1'b0, 16'h0000, 16'h0000});
    end
    @(negedge clk); rst = 1'b0; ready = 1'b1; #1;
    checks++;
    if (obs !== {1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001, 16'h0000}) begin
      errors++;
      $display("FAIL reset_restart: got %h want %h", obs, {1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001, 16'h0000});
    end
  endtask

  task automatic test_pc_wrap;
    checks++;
    if ({obs2[65], obs2[48:0]} !== {1'b0, 16'hE800, 1'b0, 16'hFFFF, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_reset: got %h want %h", {obs2[65], obs2[48:0]},
               {1'b0, 16'hE800, 1'b0, 16'hFFFF, 16'hFFFF});
    end
    @(negedge clk); rst2 = 1'b0; #1;
    checks++;
    if (obs2 !== {1'b1, 16'hFFFF, 16'h0FFF, 1'b1, 16'h0000, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_first: got %h want %h", obs2, {1'b1, 16'hFFFF, 16'h0FFF, 1'b1, 16'h0000, 16'hFFFF});
    end
    @(negedge clk); #1;
    checks++;
    if (obs2 !== {1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_second: got %h want %h", obs2, {1'b1, 16'h0000, 16'h1000, 1'b1, 16'h0001, 16'h0000});
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; ready = 1'b1;
    test_reset();
    test_zero_wait();
    test_stall();
    test_wait_states();
    test_redirect_discard();
    test_redirect_in_hold();
    test_reset_mid_request();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
